ahb_slave_port_arbiter: RTL
===========================

# ahb_slave_port_arbiter

Parametrised per-slave AHB arbiter. It grants one of `MASTER_NUM` requesting masters access to a single slave port, in fixed-priority or round-robin mode. It tracks burst beats so that defined-length bursts are never split. It also releases an idle owner after a programmable timeout. One instance sits in front of each slave in the generated interconnect, between the master request lines and the slave-side address/data mux.

## Interface
- `MASTER_NUM`, 4: number of masters sharing this slave; legal range 2..16.
- `ARB_MODE`, 0: 0 = fixed priority (master 0 highest); 1 = round robin.
- `IDLE_LIMIT`, 4: cycles an owner may hold the grant with `htrans`=IDLE while another master requests; legal range 1..15.
- Clock is `hclk`, single domain. Reset `hreset_n` is asynchronous, active-low.
- `hclk`  in  1  clock; all state changes on the rising edge.
- `hreset_n`  in  1  asynchronous active-low reset.
- `hreq`  in  `MASTER_NUM`  per-master request, level-sensitive.
- `htrans`  in  2  HTRANS of the current owner (already muxed): 0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ.
- `hburst`  in  3  HBURST of the current owner (`burst_type` encoding from `AHB_package`).
- `hready`  in  1  slave ready; a beat is accepted on an edge where `hready`=1.
- `hgrant`  out  `MASTER_NUM`  one-hot grant, registered; all-zero when no owner.
- `hsel`  out  1  slave select, equal to OR-reduction of `hgrant`.
- `hmaster`  out  max(1,$clog2(`MASTER_NUM`))  index of the owner; holds the last owner when idle.
- `hlast`  out  1  high while the next accepted beat is the final beat of a defined-length burst.

## Operation
- Three states:
  - IDLE: no owner.
  - OWN: owner granted; no burst in progress.
  - BURST: owner is inside a defined-length burst.
- Winner selection is combinational over `hreq`:
  - Fixed mode: lowest requesting index wins.
  - Round-robin mode: search starts at `rr_ptr`+1 and wraps modulo `MASTER_NUM`. `rr_ptr` is loaded with the winner index at each new grant.
- IDLE:
  - Any `hreq` bit set → load the winner into `hgrant`/`hmaster` and go to OWN.
  - Otherwise stay in IDLE.
- OWN, with a beat accepted (NONSEQ with `hready`=1):
  - `hburst`=SINGLE: transaction complete; re-arbitrate this edge.
  - INCR4/WRAP4, INCR8/WRAP8, INCR16/WRAP16: load beat limit 4/8/16, load count=1, go to BURST.
  - INCR (undefined length): stay in OWN. The owner keeps the grant while its `hreq`=1.
- OWN, releasing the grant:
  - Owner `hreq`=0 and `htrans`=IDLE with `hready`=1 → re-arbitrate.
  - Idle timeout: `htrans`=IDLE for `IDLE_LIMIT` consecutive cycles while another master requests → re-arbitrate.
- BURST:
  - count increments on every accepted SEQ beat. BUSY beats do not count.
  - When count reaches the limit, the burst is complete → re-arbitrate.
  - `hreq` is ignored inside BURST; defined bursts are never split.
- Early termination in BURST:
  - NONSEQ accepted → restart count at 1 with the new `hburst`; stay in BURST, or OWN if the new burst is SINGLE/INCR.
  - IDLE accepted → go to OWN.
- Re-arbitrate means:
  - Winner present → grant the winner and go to OWN. The same master may win again in fixed mode.
  - No requester → `hgrant`=0 and go to IDLE.
- Widths and counters:
  - count is 5 bits; limit values 1..16.
  - Idle counter is 4 bits and saturates at `IDLE_LIMIT`. It clears on any non-IDLE `htrans` and on every grant change.

## Timing
- Reset values:
  - `hgrant`=0, `hsel`=0, `hmaster`=0, `hlast`=0.
  - state IDLE, count 0, idle counter 0.
  - `rr_ptr`=`MASTER_NUM`-1, so master 0 wins first in round-robin mode.
- Reset asserted mid-burst clears everything immediately and asynchronously. No completion beat is generated.
- Request latency: `hreq` sampled high in IDLE at edge n → `hgrant` valid after edge n (1 cycle).
- Handover: the edge that accepts the final beat also loads the new grant. There are no dead cycles between back-to-back owners.
- `hlast` is combinational from state and count: 1 in BURST when count = limit-1 (after at least 1 beat). For SINGLE, `hlast`=0.
- `hready`=0 freezes count, idle counter and grant.

## Test plan
- Fixed mode, `hreq`=4'b1010 from IDLE → after 1 edge `hgrant`=4'b0010, `hmaster`=1. Master 1 drops its request after a SINGLE beat → next grant 4'b1000.
- Round-robin mode, `hreq`=4'b1111 held, each owner issues SINGLE → grant order 0,1,2,3,0, with one new grant per accepted beat.
- INCR4 with `hreq` of owner dropped after NONSEQ, `hready` low for 2 cycles mid-burst, another master requesting → grant held for exactly 4 accepted beats. `hlast` is high only before beat 4.
- INCR undefined, 6 beats, then `htrans`=IDLE and `hreq`=0 → release on that edge. `hgrant`=0 if no other request.
- Owner idles 4 cycles (`IDLE_LIMIT`=4) while master 2 requests → `hgrant` moves to master 2 after the 4th idle edge.
- `hreset_n` pulsed low during beat 3 of INCR8 → outputs clear at once. After release, state is IDLE with count 0.

Source files
------------

// File: rtl/ahb_slave_port_arbiter.sv
// rtl/ahb_slave_port_arbiter.sv - per-slave AHB arbiter with burst tracking and idle timeout

module ahb_slave_port_arbiter #(
   parameter  int MASTER_NUM = 4,
   parameter  int ARB_MODE   = 0,
   parameter  int IDLE_LIMIT = 4,
   localparam int MW         = (MASTER_NUM > 2) ? $clog2(MASTER_NUM) : 1
) (
   input  logic                  hclk,
   input  logic                  hreset_n,
   input  logic [MASTER_NUM-1:0] hreq,
   input  logic [1:0]            htrans,
   input  logic [2:0]            hburst,
   input  logic                  hready,
   output logic [MASTER_NUM-1:0] hgrant,
   output logic                  hsel,
   output logic [MW-1:0]         hmaster,
   output logic                  hlast
);

   localparam logic [1:0] TR_IDLE   = 2'd0;
   localparam logic [1:0] TR_BUSY   = 2'd1;
   localparam logic [1:0] TR_NONSEQ = 2'd2;
   localparam logic [1:0] TR_SEQ    = 2'd3;

   localparam logic [2:0] HB_SINGLE = 3'd0;
   localparam logic [2:0] HB_INCR   = 3'd1;
   localparam logic [2:0] HB_WRAP4  = 3'd2;
   localparam logic [2:0] HB_INCR4  = 3'd3;
   localparam logic [2:0] HB_WRAP8  = 3'd4;
   localparam logic [2:0] HB_INCR8  = 3'd5;
   localparam logic [2:0] HB_WRAP16 = 3'd6;
   localparam logic [2:0] HB_INCR16 = 3'd7;

   localparam logic [3:0] IDLE_LIM4 = 4'(IDLE_LIMIT);
   localparam logic [4:0] IDLE_LIM5 = 5'(IDLE_LIMIT);

   typedef enum logic [1:0] {ST_IDLE, ST_OWN, ST_BURST} state_t;

   state_t                  state_q, state_d;
   logic [MASTER_NUM-1:0]   grant_d;
   logic [MW-1:0]           master_d;
   logic [MW-1:0]           rr_ptr_q, rr_d;
   logic [4:0]              count_q, count_d;
   logic [4:0]              limit_q, limit_d;
   logic [3:0]              idle_q, idle_d;
   logic                    rearb, rearb_oth;
   logic [MW:0]             sel;
   logic [MW:0]             pick_all, pick_oth;
   logic [4:0]              beats;
   logic                    owner_req, others_req;

   // Returns {found, index} of the winning requester; the search origin depends on mode.
   function automatic logic [MW:0] pick(input logic [MASTER_NUM-1:0] req,
                                        input logic [MW-1:0] ptr);
      logic          found;
      logic [MW-1:0] idx;
      int            start;
      int            j;
      found = 1'b0;
      idx   = '0;
      start = (ARB_MODE == 1) ? int'(ptr) + 1 : 0;
      if (start >= MASTER_NUM) start = 0;
      for (int i = 0; i < MASTER_NUM; i++) begin
         j = start + i;
         if (j >= MASTER_NUM) j = j - MASTER_NUM;
         if (!found && req[j]) begin
            found = 1'b1;
            idx   = MW'(j);
         end
      end
      return {found, idx};
   endfunction

   // Beat count of a defined-length burst; zero for SINGLE and undefined INCR.
   function automatic logic [4:0] burst_beats(input logic [2:0] hb);
      case (hb)
         HB_WRAP4,  HB_INCR4:  return 5'd4;
         HB_WRAP8,  HB_INCR8:  return 5'd8;
         HB_WRAP16, HB_INCR16: return 5'd16;
         HB_SINGLE, HB_INCR:   return 5'd0;
         default:              return 5'd0;
      endcase
   endfunction

   assign beats      = burst_beats(hburst);
   assign owner_req  = |(hreq & hgrant);
   assign others_req = |(hreq & ~hgrant);
   assign pick_all   = pick(hreq, rr_ptr_q);
   // A timed-out owner is excluded so the waiting master actually gets the port.
   assign pick_oth   = pick(hreq & ~hgrant, rr_ptr_q);

   assign hsel  = |hgrant;
   assign hlast = (state_q == ST_BURST) && (count_q == limit_q - 5'd1);

   // State, grant and counter registers; reset clears everything immediately.
   always_ff @(posedge hclk or negedge hreset_n) begin
      if (!hreset_n) begin
         state_q  <= ST_IDLE;
         hgrant   <= '0;
         hmaster  <= '0;
         rr_ptr_q <= MW'(MASTER_NUM - 1);
         count_q  <= '0;
         limit_q  <= '0;
         idle_q   <= '0;
      end else begin
         state_q  <= state_d;
         hgrant   <= grant_d;
         hmaster  <= master_d;
         rr_ptr_q <= rr_d;
         count_q  <= count_d;
         limit_q  <= limit_d;
         idle_q   <= idle_d;
      end
   end

   // Next-state logic: nothing moves unless the slave accepts the beat.
   always_comb begin
      state_d   = state_q;
      grant_d   = hgrant;
      master_d  = hmaster;
      rr_d      = rr_ptr_q;
      count_d   = count_q;
      limit_d   = limit_q;
      idle_d    = idle_q;
      rearb     = 1'b0;
      rearb_oth = 1'b0;
      sel       = '0;

      if (hready) begin
         case (state_q)
            ST_IDLE: begin
               if (|hreq) rearb = 1'b1;
            end
            ST_OWN: begin
               if (htrans == TR_NONSEQ) begin
                  idle_d = '0;
                  if (hburst == HB_SINGLE) begin
                     rearb = 1'b1;
                  end else if (beats != 5'd0) begin
                     limit_d = beats;
                     count_d = 5'd1;
                     state_d = ST_BURST;
                  end
               end else if (htrans == TR_IDLE) begin
                  if (!owner_req) begin
                     rearb = 1'b1;
                  end else if (others_req && ({1'b0, idle_q} + 5'd1 >= IDLE_LIM5)) begin
                     rearb_oth = 1'b1;
                  end else if (idle_q < IDLE_LIM4) begin
                     idle_d = idle_q + 4'd1;
                  end
               end else begin
                  idle_d = '0;
               end
            end
            ST_BURST: begin
               idle_d = '0;
               case (htrans)
                  TR_SEQ: begin
                     if (count_q + 5'd1 == limit_q) rearb = 1'b1;
                     else                           count_d = count_q + 5'd1;
                  end
                  TR_NONSEQ: begin
                     if (beats != 5'd0) begin
                        limit_d = beats;
                        count_d = 5'd1;
                     end else begin
                        count_d = '0;
                        state_d = ST_OWN;
                     end
                  end
                  TR_IDLE: begin
                     count_d = '0;
                     state_d = ST_OWN;
                  end
                  TR_BUSY: begin
                     count_d = count_q;
                  end
                  default: begin
                     count_d = count_q;
                  end
               endcase
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end

      if (rearb || rearb_oth) begin
         sel     = rearb_oth ? pick_oth : pick_all;
         idle_d  = '0;
         count_d = '0;
         if (sel[MW]) begin
            grant_d             = '0;
            grant_d[sel[MW-1:0]] = 1'b1;
            master_d            = sel[MW-1:0];
            rr_d                = sel[MW-1:0];
            state_d             = ST_OWN;
         end else begin
            grant_d = '0;
            state_d = ST_IDLE;
         end
      end
   end

endmodule
